// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for APB completers
package apb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam int STRB_W = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_RANGE,
    ERR_PROT
  } err_cause_t;

endpackage

// File: rtl/apb_addr_check.sv
// rtl/apb_addr_check.sv - combinational paddr decode into word index and error cause
module apb_addr_check
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    PROT_START = 192,
  parameter int                    IDX_W      = 8
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [2:0]            pprot,
  output logic [IDX_W-1:0]      idx,
  output err_cause_t            err_cause
);

  // One extra bit so an address below BASE_ADDR shows up as a borrow.
  logic [ADDR_WIDTH:0]   offset;
  logic [ADDR_WIDTH-3:0] word;
  logic                  unused_offset_lsbs;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  prot_violation;

  assign offset             = {1'b0, paddr} - {1'b0, BASE_ADDR};
  assign word               = offset[ADDR_WIDTH-1:2];
  assign unused_offset_lsbs = &{1'b0, offset[1:0]};
  assign idx                = word[IDX_W-1:0];

  assign misaligned     = |paddr[1:0];
  assign out_of_range   = offset[ADDR_WIDTH] || (word >= (ADDR_WIDTH-2)'(MEM_DEPTH));
  assign prot_violation = pwrite && !pprot[0] && (word >= (ADDR_WIDTH-2)'(PROT_START));

  always_comb begin
    err_cause = ERR_NONE;
    if (misaligned)          err_cause = ERR_ALIGN;
    else if (out_of_range)   err_cause = ERR_RANGE;
    else if (prot_violation) err_cause = ERR_PROT;
  end

endmodule

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB4 register-memory completer with wait states and error responses
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 2,
  parameter int                    PROT_START  = 192
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_W-1:0]     pstrb,
  input  logic [2:0]            pprot,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_t                state;
  logic [3:0]            cnt;
  logic [IDX_W-1:0]      idx_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_W-1:0]     pstrb_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0]      idx;
  err_cause_t            err_cause;

  apb_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .BASE_ADDR  (BASE_ADDR),
    .PROT_START (PROT_START),
    .IDX_W      (IDX_W)
  ) u_addr_check (
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pprot     (pprot),
    .idx       (idx),
    .err_cause (err_cause)
  );

  assign pready  = (state == ACCESS) && (cnt == 4'd0);
  assign pslverr = pready && err_q;
  assign prdata  = (pready && !pwrite_q && !err_q) ? mem[idx_q] : '0;

  // Decode happens on the setup edge; the access phase only uses the latched copies.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      idx_q    <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      err_q    <= 1'b0;
      for (int w = 0; w < MEM_DEPTH; w++) mem[w] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state    <= ACCESS;
            cnt      <= 4'(WAIT_CYCLES);
            idx_q    <= idx;
            pwrite_q <= pwrite;
            pwdata_q <= pwdata;
            pstrb_q  <= pstrb;
            err_q    <= (err_cause != ERR_NONE);
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (penable) begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              if (pwrite_q && !err_q) begin
                for (int i = 0; i < STRB_W; i++)
                  if (pstrb_q[i]) mem[idx_q][i*BYTE_W +: BYTE_W] <= pwdata_q[i*BYTE_W +: BYTE_W];
              end
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - directed vector bench for apb_mem_slave
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  psel_v;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [2:0]  pready_v;
  logic [2:0]  pslverr_v;
  logic [31:0] prdata_v [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Three instances share the bus; only the one whose psel is high sees traffic.
  apb_mem_slave #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rstn(rstn), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_v[0]), .prdata(prdata_v[0]), .pslverr(pslverr_v[0]));

  apb_mem_slave #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rstn(rstn), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_v[1]), .prdata(prdata_v[1]), .pslverr(pslverr_v[1]));

  apb_mem_slave #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rstn(rstn), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_v[2]), .prdata(prdata_v[2]), .pslverr(pslverr_v[2]));

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_cyc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel_v  = 3'b000;
    penable = 1'b0;
  endtask

  task automatic setup_phase(input int d, input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot);
    @(negedge clk);
    psel_v  = 3'(1 << d);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    pprot   = prot;
  endtask

  // Full transfer; returns data/err sampled while pready is high and the access-cycle count.
  task automatic apb_xfer(input int d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                          output logic [31:0] rdata, output logic err, output int cyc);
    setup_phase(d, wr, addr, data, strb, prot);
    @(negedge clk);
    penable = 1'b1;
    pwdata  = ~data;
    cyc     = 1;
    while (!pready_v[d] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!pready_v[d]) chk("pready_timeout", 32'(pready_v[d]), 32'd1);
    rdata = prdata_v[d];
    err   = pslverr_v[d];
  endtask

  vec_t        vecs [15];
  logic [31:0] rd;
  logic        er;
  int          cyc;

  initial begin
    vecs[0]  = '{1'b1, 32'h010, 32'hDEAD_BEEF, 4'hF, 3'b000, 32'h0,          1'b0, 3};
    vecs[1]  = '{1'b0, 32'h010, 32'h0,         4'h0, 3'b000, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[2]  = '{1'b1, 32'h020, 32'h1122_3344, 4'hF, 3'b000, 32'h0,          1'b0, 3};
    vecs[3]  = '{1'b1, 32'h020, 32'hAABB_CCDD, 4'h5, 3'b000, 32'h0,          1'b0, 3};
    vecs[4]  = '{1'b0, 32'h020, 32'h0,         4'h0, 3'b000, 32'h11BB_33DD, 1'b0, 3};
    vecs[5]  = '{1'b0, 32'h402, 32'h0,         4'h0, 3'b000, 32'h0,          1'b1, 3};
    vecs[6]  = '{1'b0, 32'h400, 32'h0,         4'h0, 3'b000, 32'h0,          1'b1, 3};
    vecs[7]  = '{1'b1, 32'h012, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0,          1'b1, 3};
    vecs[8]  = '{1'b0, 32'h010, 32'h0,         4'h0, 3'b000, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[9]  = '{1'b1, 32'h300, 32'hCAFE_F00D, 4'hF, 3'b000, 32'h0,          1'b1, 3};
    vecs[10] = '{1'b0, 32'h300, 32'h0,         4'h0, 3'b000, 32'h0,          1'b0, 3};
    vecs[11] = '{1'b1, 32'h300, 32'hCAFE_F00D, 4'hF, 3'b001, 32'h0,          1'b0, 3};
    vecs[12] = '{1'b0, 32'h300, 32'h0,         4'h0, 3'b000, 32'hCAFE_F00D, 1'b0, 3};
    vecs[13] = '{1'b1, 32'h2FC, 32'h1234_5678, 4'hF, 3'b000, 32'h0,          1'b0, 3};
    vecs[14] = '{1'b0, 32'h2FC, 32'h0,         4'h0, 3'b000, 32'h1234_5678, 1'b0, 3};

    rstn = 1'b0; psel_v = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pready",  32'(pready_v),  32'd0);
    chk("reset_pslverr", 32'(pslverr_v), 32'd0);
    chk("reset_prdata",  prdata_v[0],    32'd0);
    rstn = 1'b1;

    // penable without a setup phase must not start a transfer
    @(negedge clk);
    psel_v = 3'b001; penable = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_penable_ignored", 32'(pready_v[0]), 32'd0);
    bus_idle();

    for (int i = 0; i < 15; i++) begin
      apb_xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot, rd, er, cyc);
      chk($sformatf("v%0d_prdata", i),  rd,        vecs[i].exp_rdata);
      chk($sformatf("v%0d_pslverr", i), 32'(er),   32'(vecs[i].exp_err));
      chk($sformatf("v%0d_cycles", i),  32'(cyc),  32'(vecs[i].exp_cyc));
    end
    bus_idle();

    // Zero wait states, back-to-back write then read with no idle cycle between
    apb_xfer(1, 1'b1, 32'h0, 32'h5A5A_0001, 4'hF, 3'b000, rd, er, cyc);
    chk("b2b_wr_cycles", 32'(cyc), 32'd1);
    chk("b2b_wr_err",    32'(er),  32'd0);
    apb_xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    chk("b2b_rd_cycles", 32'(cyc), 32'd1);
    chk("b2b_rd_data",   rd,       32'h5A5A_0001);
    bus_idle();

    // Abort: psel dropped mid-access with three wait states
    apb_xfer(2, 1'b1, 32'h40, 32'h0102_0304, 4'hF, 3'b000, rd, er, cyc);
    chk("w3_cycles", 32'(cyc), 32'd4);
    setup_phase(2, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, 3'b001);
    @(negedge clk); penable = 1'b1;
    chk("abort_acc1_pready", 32'(pready_v[2]), 32'd0);
    @(negedge clk);
    chk("abort_acc2_pready", 32'(pready_v[2]), 32'd0);
    psel_v = 3'b000; penable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_pready_low", 32'(pready_v[2]), 32'd0);
    end
    apb_xfer(2, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    chk("abort_word_kept", rd, 32'h0102_0304);
    bus_idle();

    // Reset in the middle of a write access
    setup_phase(2, 1'b1, 32'h44, 32'h7777_7777, 4'hF, 3'b001);
    @(negedge clk); penable = 1'b1;
    @(negedge clk);
    rstn = 1'b0; psel_v = 3'b000; penable = 1'b0;
    @(negedge clk);
    chk("rst_mid_pready", 32'(pready_v[2]), 32'd0);
    rstn = 1'b1;
    apb_xfer(2, 1'b0, 32'h44, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    chk("rst_mid_word", rd, 32'h0);
    apb_xfer(2, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    chk("rst_cleared_word", rd, 32'h0);
    bus_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- APB4 completer that sits directly downstream of the APB bridge. It consumes psel/penable/paddr/pwdata/pstrb/pprot and returns pready/prdata/pslverr.
- Implements a word-addressed register memory with a programmable wait-state count, byte-strobe writes, and error responses for decode and protection violations.
- Serves as the default bus target for system bring-up and as the reference target for bridge verification.

Parameters:
- ADDR_WIDTH, 32: paddr width.
- DATA_WIDTH, 32: pwdata/prdata width; must be 32 (four byte lanes).
- MEM_DEPTH, 256: number of 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- WAIT_CYCLES, 2: wait states inserted per transfer, range 0..15.
- PROT_START, 192: first word index of the privileged-write region.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- psel  in  1  completer select from the bridge.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  4  byte-lane write strobes.
- pprot  in  3  protection; bit0 = privileged.
- pready  out  1  transfer complete.
- prdata  out  DATA_WIDTH  read data; valid only when pready=1 and pwrite=0.
- pslverr  out  1  error response; valid only when pready=1.

Behaviour:
- Reset: reset is rstn, synchronous, active-low; clock is clk. While rstn=0 at a clk edge:
  - state goes to IDLE and the wait counter goes to 0;
  - all memory words are cleared to 0;
  - pready=0, pslverr=0, prdata=0.
- FSM states: IDLE, ACCESS.
  - IDLE → ACCESS when psel=1 and penable=0 are sampled (setup phase).
  - On that edge, latch paddr, pwrite, pwdata, pstrb and pprot, load cnt=WAIT_CYCLES, and latch err_q.
- ACCESS behaviour:
  - If psel=1 and penable=1 and cnt≠0: decrement cnt.
  - pready = (state==ACCESS && cnt==0), combinational from registers.
  - The access phase therefore lasts WAIT_CYCLES+1 cycles. For WAIT_CYCLES=0, pready=1 in the first access cycle.
- Completion edge (state==ACCESS, pready=1, psel=1, penable=1):
  - If the transfer is a write and err_q=0: for each lane i with pstrb_q[i]=1, write mem[idx][8i+7:8i] = pwdata_q lane i. Lanes with pstrb=0 are unchanged.
  - State returns to IDLE.
- Read data: prdata = mem[idx] when pready=1, pwrite_q=0 and err_q=0; otherwise prdata=0.
- Error response: pslverr = pready & err_q. An errored transfer writes nothing and returns prdata=0.
- err_q is set when any of the following holds:
  - paddr[1:0] ≠ 0 (misaligned);
  - paddr < BASE_ADDR, or idx = (paddr−BASE_ADDR)>>2 ≥ MEM_DEPTH (out of range); subtraction is done at ADDR_WIDTH+1 bits so underflow is detected;
  - pwrite=1, idx ≥ PROT_START and pprot[0]=0 (unprivileged write to the protected region).
  - Reads of the protected region are always allowed.
- Address and control are taken from the latched copies only. Changes on the bus during the access phase are ignored.
- Back-to-back transfers: after the completion edge the FSM is in IDLE. A new setup (psel=1, penable=0) in the next cycle starts the next transfer, giving zero idle cycles.
- Protocol violation: psel=0 while in ACCESS aborts the transfer. State goes to IDLE, nothing is written, and pready stays 0.
- penable=1 while in IDLE is ignored (no setup detected).
- Reset mid-transfer: the pending write is discarded and pready drops at the next edge.

Decomposition:
- apb_pkg holds:
  - the state enum (IDLE, ACCESS);
  - constants STRB_W=4 and BYTE_W=8;
  - the error-cause enum (ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_PROT), exposed for debug.
- Sub-module apb_addr_check: combinational decode of paddr/pwrite/pprot into idx and an error cause. It is reused by future completers.

Test Plan:
- WAIT_CYCLES=2. Write 32'hDEAD_BEEF to 0x10 with pstrb=4'hF, then read 0x10 → pready high on the 3rd access cycle of each transfer; prdata=32'hDEAD_BEEF; pslverr=0.
- Write 32'h1122_3344 to 0x20 with pstrb=4'hF, then write 32'hAABB_CCDD with pstrb=4'b0101 → a read of 0x20 returns 32'h11BB_33DD.
- Read 0x402 (misaligned), then read 0x400 (out of range, MEM_DEPTH=256) → each completes with pslverr=1, prdata=0, and memory is unchanged.
- Write to 0x300 (idx 192) with pprot=3'b000 → pslverr=1, word unchanged. Repeat with pprot=3'b001 → pslverr=0 and the read-back matches.
- Back-to-back transfers with WAIT_CYCLES=0: write 0x0, then read 0x0 in consecutive cycles → pready=1 in each access cycle and the read returns the written data.
- Abort and reset:
  - Drop psel during a write access (WAIT_CYCLES=3) → pready never asserts and the word is unchanged.
  - Assert rstn=0 during a write access → the next read returns 0.
